// File: rtl/sram_dp_clr.sv
// sram_dp_clr: simple dual-port scratch RAM with per-byte write enables,
// a 1-cycle registered read port and a built-in clear sequencer. The clear
// sequencer zeroes every word after reset or on request. While it runs,
// accesses are dropped and flagged on rej_o.
module sram_dp_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RDW_MODE = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   di_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   do_o,
  output logic                do_valid_o,
  output logic                busy_o,
  output logic                rej_o
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clrPtr_q, clrPtr_d;
  logic [DATA_W-1:0]   doData_q;
  logic                doValid_q;
  logic                rej_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mergedWord;
  logic                fwdHit;

  // State register and clear pointer; reset restarts the clear from word 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CLEAR;
      clrPtr_q <= '0;
    end else begin
      state_q  <= state_d;
      clrPtr_q <= clrPtr_d;
    end
  end

  // Next state: walk the pointer through every word, or restart on a clear request
  always_comb begin
    state_d  = state_q;
    clrPtr_d = clrPtr_q;
    case (state_q)
      CLEAR: begin
        clrPtr_d = clrPtr_q + 1'b1;
        if (clrPtr_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clr_i) begin
          clrPtr_d = '0;
          state_d  = CLEAR;
        end
      end
      default: begin
        state_d  = CLEAR;
        clrPtr_d = '0;
      end
    endcase
  end

  // Outputs: busy is decoded straight from the state register, the rest are registered
  always_comb begin
    busy_o     = (state_q == CLEAR);
    do_o       = doData_q;
    do_valid_o = doValid_q;
    rej_o      = rej_q;
  end

  // Write word after byte merging; also the forwarded value in write-first mode
  always_comb begin
    mergedWord = mem[waddr_i];
    for (int i = 0; i < NBYTES; i++) begin
      if (be_i[i]) begin
        mergedWord[8*i +: 8] = di_i[8*i +: 8];
      end
    end
  end

  // A same-address read sees the new data only when write-first mode is selected
  always_comb begin
    fwdHit = (RDW_MODE != 0) && we_i && (waddr_i == raddr_i);
  end

  // Array update: the clear sequencer owns the array while busy, otherwise the write port does
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        mem[clrPtr_q] <= '0;
      end else if (we_i) begin
        mem[waddr_i] <= mergedWord;
      end
    end
  end

  // Read port and reject flag; dropped accesses leave the read data untouched
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      doData_q  <= '0;
      doValid_q <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      rej_q <= (state_q == CLEAR) && (we_i || re_i);
      if ((state_q == READY) && re_i) begin
        doData_q  <= fwdHit ? mergedWord : mem[raddr_i];
        doValid_q <= 1'b1;
      end else begin
        doValid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_clr.sv
// tb_sram_dp_clr: directed bench for sram_dp_clr. Two 32x32 instances
// (read-old and write-first) share one stimulus stream; a 64x256 instance
// is exercised separately for the wide/deep configuration.
module tb_sram_dp_clr;

  logic        clk;
  logic        rst, clr, we, re;
  logic [4:0]  waddr, raddr;
  logic [3:0]  be;
  logic [31:0] di;
  logic [31:0] do0, do1;
  logic        dv0, dv1, busy0, busy1, rej0, rej1;

  logic        rst2, clr2, we2, re2;
  logic [7:0]  waddr2, raddr2;
  logic [7:0]  be2;
  logic [63:0] di2, do2;
  logic        dv2, busy2, rej2;

  int checks = 0;
  int errors = 0;
  int cnt;

  // Free-running clock shared by all instances
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_dp_clr #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .we_i(we), .waddr_i(waddr), .be_i(be),
    .di_i(di), .re_i(re), .raddr_i(raddr), .do_o(do0), .do_valid_o(dv0),
    .busy_o(busy0), .rej_o(rej0)
  );

  sram_dp_clr #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .we_i(we), .waddr_i(waddr), .be_i(be),
    .di_i(di), .re_i(re), .raddr_i(raddr), .do_o(do1), .do_valid_o(dv1),
    .busy_o(busy1), .rej_o(rej1)
  );

  sram_dp_clr #(.DATA_W(64), .ADDR_W(8), .RDW_MODE(0)) dut2 (
    .clk_i(clk), .rst_i(rst2), .clr_i(clr2), .we_i(we2), .waddr_i(waddr2), .be_i(be2),
    .di_i(di2), .re_i(re2), .raddr_i(raddr2), .do_o(do2), .do_valid_o(dv2),
    .busy_o(busy2), .rej_o(rej2)
  );

  // Counts one comparison and reports it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one rising edge and settles just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus onto the shared 32-bit ports
  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [3:0] b,
                               input logic [31:0] d, input logic r, input logic [4:0] ra,
                               input logic c);
    we = w; waddr = wa; be = b; di = d; re = r; raddr = ra; clr = c;
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  // Keeps ticking until the shared instances leave CLEAR, with a cycle bound
  task automatic waitClear(input string tag, input int startCnt);
    cnt = startCnt;
    while (busy0 && cnt < 40) begin
      idle();
      cnt++;
    end
    checkOutput(tag, 64'(cnt), 64'd32);
    checkOutput({tag, "_busy1"}, 64'(busy1), 64'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 0; we = 0; re = 0; waddr = 0; raddr = 0; be = 0; di = 0;
    rst2 = 1'b1; clr2 = 0; we2 = 0; re2 = 0; waddr2 = 0; raddr2 = 0; be2 = 0; di2 = 0;

    // 1: reset defaults, clear length, every word reads zero
    idle();
    checkOutput("rst_busy", 64'(busy0), 64'd1);
    checkOutput("rst_do", 64'(do0), 64'd0);
    checkOutput("rst_dv", 64'(dv0), 64'd0);
    checkOutput("rst_rej", 64'(rej0), 64'd0);
    rst = 1'b0;
    waitClear("clr_len_init", 0);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(a), 1'b0);
      checkOutput($sformatf("init_do_%0d", a), 64'(do0), 64'd0);
      checkOutput($sformatf("init_dv_%0d", a), 64'(dv0), 64'd1);
    end
    idle();
    checkOutput("idle_dv", 64'(dv0), 64'd0);

    // 2: full write then partial byte overwrite
    applyStimulus(1'b1, 5'd7, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 5'd7, 4'b0101, 32'h11223344, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    checkOutput("be_merge0", 64'(do0), 64'hDE22BE44);
    checkOutput("be_merge1", 64'(do1), 64'hDE22BE44);
    checkOutput("be_merge_dv", 64'(dv0), 64'd1);

    // Write with no byte enables changes nothing and is not rejected
    applyStimulus(1'b1, 5'd7, 4'h0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
    checkOutput("be0_rej", 64'(rej0), 64'd0);
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    checkOutput("be0_keep", 64'(do0), 64'hDE22BE44);

    // 3: same-edge read-during-write, full and partial
    applyStimulus(1'b1, 5'd3, 4'hF, 32'hAAAAAAAA, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 5'd3, 4'hF, 32'h55555555, 1'b1, 5'd3, 1'b0);
    checkOutput("rdw_old", 64'(do0), 64'hAAAAAAAA);
    checkOutput("rdw_fwd", 64'(do1), 64'h55555555);
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b0);
    checkOutput("rdw_after0", 64'(do0), 64'h55555555);
    checkOutput("rdw_after1", 64'(do1), 64'h55555555);
    applyStimulus(1'b1, 5'd5, 4'hF, 32'h12345678, 1'b0, 5'd0, 1'b0);
    checkOutput("hold_do", 64'(do0), 64'h55555555);
    checkOutput("hold_dv", 64'(dv0), 64'd0);
    applyStimulus(1'b1, 5'd5, 4'b0011, 32'hAABBCCDD, 1'b1, 5'd5, 1'b0);
    checkOutput("rdw_part_old", 64'(do0), 64'h12345678);
    checkOutput("rdw_part_fwd", 64'(do1), 64'h1234CCDD);
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5, 1'b0);
    checkOutput("rdw_part_after", 64'(do0), 64'h1234CCDD);

    // 4: clear request with a same-edge access, then a rejected access
    applyStimulus(1'b1, 5'd9, 4'hF, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 5'd10, 4'hF, 32'h0BADF00D, 1'b1, 5'd9, 1'b1);
    checkOutput("clr_edge_busy", 64'(busy0), 64'd1);
    checkOutput("clr_edge_rd", 64'(do0), 64'hCAFEF00D);
    checkOutput("clr_edge_rej", 64'(rej0), 64'd0);
    applyStimulus(1'b1, 5'd9, 4'hF, 32'hFFFFFFFF, 1'b1, 5'd10, 1'b0);
    checkOutput("busy_rej", 64'(rej0), 64'd1);
    checkOutput("busy_dv", 64'(dv0), 64'd0);
    checkOutput("busy_do_hold", 64'(do0), 64'hCAFEF00D);
    idle();
    checkOutput("rej_pulse_end", 64'(rej0), 64'd0);
    waitClear("clr_len_req", 2);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'(a), 1'b0);
      checkOutput($sformatf("clr_do_%0d", a), 64'(do0), 64'd0);
    end

    // 5: reset in the middle of a clear restarts the full count
    applyStimulus(1'b1, 5'd1, 4'hF, 32'h13579BDF, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd1, 1'b0);
    checkOutput("pre_rst_rd", 64'(do0), 64'h13579BDF);
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    rst = 1'b1;
    idle();
    checkOutput("midrst_busy", 64'(busy0), 64'd1);
    checkOutput("midrst_do", 64'(do0), 64'd0);
    checkOutput("midrst_dv", 64'(dv0), 64'd0);
    idle();
    rst = 1'b0;
    waitClear("clr_len_rst", 0);
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd1, 1'b0);
    checkOutput("post_rst_rd", 64'(do0), 64'd0);
    checkOutput("post_rst_dv", 64'(dv0), 64'd1);

    // 6: wide and deep instance
    checkOutput("w_rst_busy", 64'(busy2), 64'd1);
    rst2 = 1'b0;
    cnt = 0;
    while (busy2 && cnt < 300) begin
      tick();
      cnt++;
    end
    checkOutput("w_clr_len", 64'(cnt), 64'd256);
    we2 = 1'b1; waddr2 = 8'd200; be2 = 8'hFF; di2 = 64'h0123456789ABCDEF;
    tick();
    be2 = 8'h80; di2 = 64'hFEDCBA9876543210;
    tick();
    we2 = 1'b0; re2 = 1'b1; raddr2 = 8'd200;
    tick();
    checkOutput("w_be80", do2, 64'hFE23456789ABCDEF);
    checkOutput("w_dv", 64'(dv2), 64'd1);
    raddr2 = 8'd255;
    tick();
    checkOutput("w_last", do2, 64'd0);
    re2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
